// File: rtl/prng_pkg.sv
// Shared types, default constants and the Galois LFSR step used by the
// PRNG fill/verify engine and its testbench-facing top.
package prng_pkg;

    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_ADDR_W = 10;
    localparam logic [31:0] DEF_TAPS   = 32'h8020_0003;

    // Widest LFSR the shared step function handles; callers zero-extend
    // their state and taps to this width and truncate the result back.
    localparam int          MAX_W      = 64;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        VRD,
        VDRAIN,
        DONE
    } state_t;

    // One Galois step: shift right, fold the taps in when the LSB was set.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                   input logic [MAX_W-1:0] taps);
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/prng_bram_fill_verify_bram_dp.sv
// Simple dual-port RAM: port A read/write, port B read-only.
// Both read ports are registered (1-cycle latency) and read-first.
module bram_dp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] qa,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] qb
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Port A write.
    // NOTE: the array has no reset so it maps onto block RAM; only the
    // output registers below are cleared.
    always_ff @(posedge clk) begin
        if (en_a && we_a) begin
            mem[addr_a] <= wdata_a;
        end
    end

    // Port A registered read; sees the old word on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa <= '0;
        end else if (en_a) begin
            qa <= mem[addr_a];
        end
    end

    // Port B registered read, always enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qb <= '0;
        end else begin
            qb <= mem[addr_b];
        end
    end

endmodule

// File: rtl/prng_bram_fill_verify.sv
// PRNG fill/verify engine: writes a Galois-LFSR sequence into BRAM, or
// regenerates it and counts mismatches against the stored words.
module prng_bram_fill_verify
    import prng_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(DEF_TAPS),
    parameter int                ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] last_value,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [DATA_W-1:0] lfsr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remain;

    // Compare pipeline: expected word and address delayed to line up
    // with the registered BRAM read data.
    logic              cmp_valid;
    logic [DATA_W-1:0] exp_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] qa;

    logic [ADDR_W:0]   cnt_clamped;
    logic [DATA_W-1:0] seed_init;
    logic [DATA_W-1:0] lfsr_step;
    logic              en_a;
    logic              we_a;

    assign cnt_clamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;
    // A zero seed would lock the LFSR at zero forever.
    assign seed_init   = (seed == '0) ? DATA_W'(1) : seed;
    assign lfsr_step   = DATA_W'(lfsr_next(MAX_W'(lfsr), MAX_W'(TAPS)));
    assign en_a        = (state == FILL) || (state == VRD);
    assign we_a        = (state == FILL);

    bram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_a    (en_a),
        .we_a    (we_a),
        .addr_a  (addr),
        .wdata_a (lfsr),
        .qa      (qa),
        .addr_b  (rd_addr),
        .qb      (rd_data)
    );

    // Control FSM, address/LFSR generation and the verify compare stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            last_value     <= '0;
            lfsr           <= '0;
            addr           <= '0;
            remain         <= '0;
            cmp_valid      <= 1'b0;
            exp_d          <= '0;
            addr_d         <= '0;
        end else begin
            // NOTE: pulse-type registers get a default here so every branch
            // below only has to name the cycle where they go high.
            done      <= 1'b0;
            cmp_valid <= 1'b0;

            if (cmp_valid) begin
                last_value <= exp_d;
                if (qa != exp_d) begin
                    if (err_count == '0) begin
                        first_err_addr <= addr_d;
                    end
                    if (err_count != DEPTH_CNT) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr   <= seed_init;
                        addr   <= start_addr;
                        remain <= cnt_clamped;
                        if (mode) begin
                            err_count      <= '0;
                            first_err_addr <= '0;
                        end
                        if (cnt_clamped == '0) begin
                            err_count <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= mode ? VRD : FILL;
                        end
                    end
                end
                FILL: begin
                    last_value <= lfsr;
                    lfsr       <= lfsr_step;
                    addr       <= addr + 1'b1;
                    remain     <= remain - 1'b1;
                    if (remain == ONE_CNT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                VRD: begin
                    cmp_valid <= 1'b1;
                    exp_d     <= lfsr;
                    addr_d    <= addr;
                    lfsr      <= lfsr_step;
                    addr      <= addr + 1'b1;
                    remain    <= remain - 1'b1;
                    if (remain == ONE_CNT) begin
                        state <= VDRAIN;
                    end
                end
                VDRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prng_bram_fill_verify.sv
// Scoreboard bench for prng_bram_fill_verify: each issued operation pushes
// its expected completion record, each external read pushes its expected
// word; a negedge monitor pops and compares when the DUT presents them.
module tb_prng_bram_fill_verify;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] seed;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] start_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] last_value;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    prng_bram_fill_verify #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .seed           (seed),
        .count          (count),
        .start_addr     (start_addr),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .last_value     (last_value),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                done_cyc;
        int                busy_cycles;
        logic [ADDR_W:0]   err;
        logic [ADDR_W-1:0] first;
        logic [DATA_W-1:0] last;
    } exp_t;

    exp_t              done_q[$];
    logic [DATA_W-1:0] rd_q[$];

    // Reference model of the memory and the held result registers.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_err   = 0;
    int                m_first = 0;
    logic [DATA_W-1:0] m_last  = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    // Monitor: completion records on done, read data one cycle after a read.
    int   busy_cnt = 0;
    logic rd_req   = 1'b0;
    logic rd_vld   = 1'b0;

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        exp_t              e;
        logic [DATA_W-1:0] rv;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.busy_cycles));
                    check("err_count", 64'(err_count), 64'(e.err));
                    check("first_err_addr", 64'(first_err_addr), 64'(e.first));
                    check("last_value", 64'(last_value), 64'(e.last));
                end
                busy_cnt = 0;
            end
        end
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                check("unexpected_rd", 64'd1, 64'd0);
            end else begin
                rv = rd_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(rv));
            end
        end
    end

    // Issue one operation and push its expected completion record.
    task automatic issue(input bit md, input logic [31:0] sd, input int cnt, input int sa);
        int          c;
        int          a;
        logic [31:0] s;
        exp_t        e;
        @(negedge clk);
        start      = 1'b1;
        mode       = md;
        seed       = sd;
        count      = cnt[ADDR_W:0];
        start_addr = sa[ADDR_W-1:0];
        c = (cnt > DEPTH) ? DEPTH : cnt;
        s = (sd == 0) ? 32'd1 : sd;
        if (md) begin
            m_err   = 0;
            m_first = 0;
        end
        for (int k = 0; k < c; k++) begin
            a = (sa + k) % DEPTH;
            if (!md) begin
                m_mem[a] = s;
            end else if (m_mem[a] !== s) begin
                if (m_err == 0) m_first = a;
                m_err++;
            end
            m_last = s;
            s = step(s);
        end
        if (c == 0) m_err = 0;
        e.done_cyc    = cyc + ((c == 0) ? 1 : (md ? c + 2 : c + 1));
        e.busy_cycles = (c == 0) ? 0 : (md ? c + 1 : c);
        e.err         = (ADDR_W + 1)'(m_err);
        e.first       = ADDR_W'(m_first);
        e.last        = m_last;
        done_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_q.size() != 0; i++) @(negedge clk);
        check("done_timeout", 64'(done_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic rd(input int a, input logic [31:0] expv);
        @(negedge clk);
        rd_addr = a[ADDR_W-1:0];
        rd_req  = 1'b1;
        rd_q.push_back(expv);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rd_model(input int a);
        rd(a, m_mem[a]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] old;
        logic [31:0] fs;
        int          fsa;
        int          fcnt;
        logic [31:0] s9;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0;
        count = '0; start_addr = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_first_err", 64'(first_err_addr), 64'd0);
        check("rst_last_value", 64'(last_value), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic fill, read back against the known sequence.
        issue(1'b0, 32'd1, 4, 'h00F);
        wait_done();
        rd('h00F, 32'h0000_0001);
        rd('h010, 32'h8020_0003);
        rd('h011, 32'hC030_0002);
        rd('h012, 32'h6018_0001);

        // Fill across the top of the address space.
        issue(1'b0, 32'd1, 4, 'h3FE);
        wait_done();
        rd('h3FE, 32'h0000_0001);
        rd('h3FF, 32'h8020_0003);
        rd('h000, 32'hC030_0002);
        rd('h001, 32'h6018_0001);

        // Verify: matching seed, then a wrong seed.
        issue(1'b1, 32'd1, 4, 'h00F);
        wait_done();
        issue(1'b1, 32'd2, 4, 'h00F);
        wait_done();

        // Zero-seed substitution, then a zero-length operation.
        issue(1'b0, 32'd0, 2, 'h100);
        wait_done();
        rd('h100, 32'h0000_0001);
        rd('h101, 32'h8020_0003);
        issue(1'b0, 32'd5, 0, 'h100);
        wait_done();
        rd_model('h100);

        // Pre-fill, then refill with a collision read and an ignored start.
        issue(1'b0, 32'd5, 8, 'h200);
        wait_done();
        old = m_mem['h200];
        issue(1'b0, 32'd11, 8, 'h200);
        rd_addr = 10'h200;
        rd_req  = 1'b1;
        rd_q.push_back(old);
        @(negedge clk);
        rd_req = 1'b0;
        start = 1'b1; mode = 1'b1; count = 11'd3; seed = 32'hDEAD_BEEF; start_addr = 10'h050;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        for (int i = 0; i < 8; i++) rd_model('h200 + i);

        // Oversized count clamps to a full-memory fill; verify it whole.
        fs = $urandom;
        issue(1'b0, fs, DEPTH + 1, 'h155);
        wait_done();
        issue(1'b1, fs, DEPTH, 'h155);
        wait_done();
        rd_model('h154);
        rd_model('h155);

        // Randomised operations against the model.
        fs = 32'd1; fsa = 'h00F; fcnt = 4;
        for (int n = 0; n < 14; n++) begin
            bit          md;
            logic [31:0] sd;
            int          cnt;
            int          sa;
            md  = 1'($urandom_range(0, 1));
            sd  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            sa  = $urandom_range(0, DEPTH - 1);
            if (md && $urandom_range(0, 1) == 1) begin
                sd = fs; sa = fsa; cnt = fcnt;
            end
            if (!md && cnt > 0) begin
                fs = sd; fsa = sa; fcnt = cnt;
            end
            issue(md, sd, cnt, sa);
            wait_done();
            for (int r = 0; r < 3; r++) rd_model((sa + $urandom_range(0, 40)) % DEPTH);
        end

        // Reset in the middle of a fill: two words land, then abort.
        issue(1'b0, 32'd7, 8, 'h300);
        wait_done();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; seed = 32'd9; count = 11'd8; start_addr = 10'h300;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_last_value", 64'(last_value), 64'd0);
        check("abort_err_count", 64'(err_count), 64'd0);
        check("abort_rd_data", 64'(rd_data), 64'd0);
        s9 = 32'd9;
        m_mem['h300] = s9;
        m_mem['h301] = step(s9);
        m_last = '0; m_err = 0; m_first = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) rd_model('h300 + i);
        issue(1'b1, 32'd9, 2, 'h300);
        wait_done();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(done_q.size() + rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
